// File: rtl/counter_heap_sched.sv
// counter_heap_sched: in-order update queue and decay scheduler in front of the 2-bit counter heap
module counter_heap_sched #(
  parameter int COUNTERPW = 5,
  parameter int COUNTERWIDE = 2,
  parameter int QDEPTH = 4,
  parameter int QPW = 2,
  parameter int ATTPERIOD = 1024,
  parameter int ATTCW = 16,
  parameter int ATTMAXWAIT = 8
) (
  input  logic                   Clk,
  input  logic                   Rest,
  input  logic                   Req0Valid,
  input  logic [COUNTERPW-1:0]   Req0Addr,
  input  logic [COUNTERWIDE-1:0] Req0Right,
  output logic                   Req0Ready,
  input  logic                   Req1Valid,
  input  logic [COUNTERPW-1:0]   Req1Addr,
  input  logic [COUNTERWIDE-1:0] Req1Right,
  output logic                   Req1Ready,
  input  logic                   AttenEnable,
  output logic [COUNTERPW-1:0]   UpAddr,
  output logic                   UpdateAble,
  output logic [COUNTERWIDE-1:0] RightOrFault,
  output logic                   Attenuation,
  output logic [QPW:0]           QueueCount,
  output logic                   Busy
);
  localparam int CW = QPW + 1;
  localparam int WW = $clog2(ATTMAXWAIT + 1);
  logic [COUNTERPW-1:0] q_addr [QDEPTH];
  logic [COUNTERWIDE-1:0] q_right [QDEPTH];
  logic [QPW-1:0] rd_ptr;
  logic [QPW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [ATTCW-1:0] per_cnt;
  logic [WW-1:0] wait_cnt;
  logic att_pending;
  logic push0;
  logic push1;
  logic issue;
  logic pop;
  logic expire;
  always_comb begin
    Req0Ready = count < CW'(QDEPTH);
    Req1Ready = (count <= CW'(QDEPTH - 2)) || (count == CW'(QDEPTH - 1) && !Req0Valid);
    push0 = Req0Valid && Req0Ready;
    push1 = Req1Valid && Req1Ready;
    issue = att_pending && (count == '0 || wait_cnt == WW'(ATTMAXWAIT));
    pop = count != '0 && !issue;
    expire = per_cnt == ATTCW'(ATTPERIOD - 1);
    QueueCount = count;
    Busy = count != '0 || att_pending;
  end
  always_ff @(posedge Clk) begin
    if (push0) begin
      q_addr[wr_ptr] <= Req0Addr;
      q_right[wr_ptr] <= Req0Right;
    end
    if (push1) begin
      q_addr[wr_ptr + QPW'(push0)] <= Req1Addr;
      q_right[wr_ptr + QPW'(push0)] <= Req1Right;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rest) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      per_cnt <= '0;
      wait_cnt <= '0;
      att_pending <= 1'b0;
      UpAddr <= '0;
      RightOrFault <= '0;
      UpdateAble <= 1'b0;
      Attenuation <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + QPW'(push0) + QPW'(push1);
      rd_ptr <= rd_ptr + QPW'(pop);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
      UpdateAble <= pop;
      Attenuation <= issue;
      if (pop) begin
        UpAddr <= q_addr[rd_ptr];
        RightOrFault <= q_right[rd_ptr];
      end
      if (!AttenEnable) begin
        per_cnt <= '0;
        wait_cnt <= '0;
        att_pending <= 1'b0;
      end else begin
        per_cnt <= expire ? '0 : per_cnt + ATTCW'(1);
        wait_cnt <= issue ? '0 : wait_cnt + WW'(att_pending);
        att_pending <= !issue && (att_pending || expire);
      end
    end
  end
endmodule

// File: tb/tb_counter_heap_sched.sv
// tb_counter_heap_sched: vector table, directed attenuation/reset sequences and randomized model check
module tb_counter_heap_sched;
  localparam int AW = 5;
  localparam int RW = 2;
  localparam int QD = 4;
  localparam int QPW = 2;
  localparam int AP = 16;
  localparam int MW = 8;
  logic Clk = 1'b0;
  logic Rest;
  logic Req0Valid;
  logic Req1Valid;
  logic AttenEnable;
  logic [AW-1:0] Req0Addr;
  logic [AW-1:0] Req1Addr;
  logic [AW-1:0] UpAddr;
  logic [RW-1:0] Req0Right;
  logic [RW-1:0] Req1Right;
  logic [RW-1:0] RightOrFault;
  logic Req0Ready;
  logic Req1Ready;
  logic UpdateAble;
  logic Attenuation;
  logic Busy;
  logic [QPW:0] QueueCount;
  int passed = 0;
  int total = 0;
  always #5 Clk = ~Clk;
  counter_heap_sched #(
    .COUNTERPW(AW), .COUNTERWIDE(RW), .QDEPTH(QD), .QPW(QPW),
    .ATTPERIOD(AP), .ATTCW(16), .ATTMAXWAIT(MW)
  ) dut (
    .Clk(Clk), .Rest(Rest),
    .Req0Valid(Req0Valid), .Req0Addr(Req0Addr), .Req0Right(Req0Right), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Addr(Req1Addr), .Req1Right(Req1Right), .Req1Ready(Req1Ready),
    .AttenEnable(AttenEnable), .UpAddr(UpAddr), .UpdateAble(UpdateAble),
    .RightOrFault(RightOrFault), .Attenuation(Attenuation),
    .QueueCount(QueueCount), .Busy(Busy)
  );
  typedef struct packed {logic [AW-1:0] a; logic [RW-1:0] r;} ent_t;
  ent_t mq[$];
  int m_per;
  int m_wt;
  bit m_pend;
  bit m_up;
  bit m_att;
  int m_addr;
  int m_right;
  typedef struct {
    bit rst; bit v0; int a0; int r0; bit v1; int a1; int r1;
    bit x0; bit x1; bit xup; int xaddr; int xqc;
  } vec_t;
  vec_t vt[16];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic model_reset();
    mq.delete();
    m_per = 0;
    m_wt = 0;
    m_pend = 0;
    m_up = 0;
    m_att = 0;
    m_addr = 0;
    m_right = 0;
  endtask
  task automatic set_in(input bit v0, input int a0, input int r0, input bit v1, input int a1, input int r1);
    Req0Valid = v0;
    Req0Addr = AW'(a0);
    Req0Right = RW'(r0);
    Req1Valid = v1;
    Req1Addr = AW'(a1);
    Req1Right = RW'(r1);
  endtask
  task automatic step();
    int fr;
    bit e0, e1, iss, pop, ex;
    ent_t ent;
    #1;
    fr = QD - mq.size();
    e0 = fr >= 1;
    e1 = fr >= 2 || (fr == 1 && !Req0Valid);
    chk("req0_ready", int'(Req0Ready), int'(e0));
    chk("req1_ready", int'(Req1Ready), int'(e1));
    iss = m_pend && (mq.size() == 0 || m_wt == MW);
    pop = mq.size() != 0 && !iss;
    if (Rest) model_reset();
    else begin
      m_att = iss;
      m_up = pop;
      if (pop) begin
        ent = mq.pop_front();
        m_addr = int'(ent.a);
        m_right = int'(ent.r);
      end
      if (Req0Valid && e0) mq.push_back({Req0Addr, Req0Right});
      if (Req1Valid && e1) mq.push_back({Req1Addr, Req1Right});
      if (!AttenEnable) begin
        m_per = 0;
        m_pend = 0;
        m_wt = 0;
      end else begin
        ex = m_per == AP - 1;
        m_per = ex ? 0 : m_per + 1;
        m_wt = iss ? 0 : (m_pend ? m_wt + 1 : m_wt);
        m_pend = !iss && (m_pend || ex);
      end
    end
    @(posedge Clk);
    #1;
    chk("update_able", int'(UpdateAble), int'(m_up));
    chk("up_addr", int'(UpAddr), m_addr);
    chk("right_or_fault", int'(RightOrFault), m_right);
    chk("attenuation", int'(Attenuation), int'(m_att));
    chk("queue_count", int'(QueueCount), mq.size());
    chk("busy", int'(Busy), int'(mq.size() != 0 || m_pend));
    chk("no_overlap", int'(UpdateAble && Attenuation), 0);
  endtask
  task automatic reset_step();
    Rest = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    step();
    Rest = 1'b0;
  endtask
  initial begin
    int t1, t2, n, ups, fa;
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    vt[1]  = '{0, 1, 5, 1, 0, 0, 0, 1, 1, 0, 0, 1};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 0};
    vt[4]  = '{0, 1, 3, 2, 1, 9, 3, 1, 1, 0, 5, 2};
    vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 1};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 9, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 9, 0};
    vt[8]  = '{0, 1, 1, 1, 1, 2, 2, 1, 1, 0, 9, 2};
    vt[9]  = '{0, 1, 3, 3, 1, 4, 0, 1, 1, 1, 1, 3};
    vt[10] = '{0, 1, 5, 1, 1, 6, 2, 1, 0, 1, 2, 3};
    vt[11] = '{0, 0, 0, 0, 1, 6, 2, 1, 1, 1, 3, 3};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 2};
    vt[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 1};
    vt[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6, 0};
    vt[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6, 0};
    Rest = 1'b1;
    AttenEnable = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      Rest = vt[i].rst;
      set_in(vt[i].v0, vt[i].a0, vt[i].r0, vt[i].v1, vt[i].a1, vt[i].r1);
      #1;
      chk("vec_r0_ready", int'(Req0Ready), int'(vt[i].x0));
      chk("vec_r1_ready", int'(Req1Ready), int'(vt[i].x1));
      step();
      chk("vec_update", int'(UpdateAble), int'(vt[i].xup));
      chk("vec_addr", int'(UpAddr), vt[i].xaddr);
      chk("vec_count", int'(QueueCount), vt[i].xqc);
    end
    Rest = 1'b0;
    reset_step();
    AttenEnable = 1'b1;
    n = 0;
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 48; i++) begin
      step();
      if (Attenuation) begin
        n++;
        if (n == 1) t1 = i;
        else if (n == 2) t2 = i;
      end
    end
    chk("natural_first", t1, 17);
    chk("natural_gap", t2 - t1, AP);
    chk("natural_pulses", n, 2);
    reset_step();
    ups = 0;
    fa = 0;
    for (int i = 1; i <= 30; i++) begin
      set_in(1, i, i % 4, 0, 0, 0);
      step();
      if (UpdateAble) ups++;
      if (Attenuation && fa == 0) begin
        fa = i;
        chk("forced_no_update", int'(UpdateAble), 0);
      end
    end
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (UpdateAble) ups++;
    end
    chk("forced_at", fa, 25);
    chk("forced_updates", ups, 30);
    reset_step();
    for (int i = 1; i <= 26; i++) begin
      set_in(1, i, 1, 1, 31 - i, 2);
      if (i == 26) begin
        #1;
        chk("full_r0_ready", int'(Req0Ready), 0);
        chk("full_r1_ready", int'(Req1Ready), 0);
      end
      step();
      if (i == 25) chk("full_count", int'(QueueCount), 4);
    end
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    reset_step();
    for (int i = 1; i <= 16; i++) begin
      set_in(1, i, 3, 1, i + 16, 1);
      step();
    end
    chk("mid_count_before", int'(QueueCount), 3);
    chk("mid_busy_before", int'(Busy), 1);
    Rest = 1'b1;
    step();
    chk("mid_count", int'(QueueCount), 0);
    chk("mid_busy", int'(Busy), 0);
    chk("mid_update", int'(UpdateAble), 0);
    chk("mid_addr", int'(UpAddr), 0);
    chk("mid_right", int'(RightOrFault), 0);
    chk("mid_atten", int'(Attenuation), 0);
    Rest = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    ups = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (UpdateAble) ups++;
      if (Attenuation) n++;
    end
    chk("mid_no_stale_updates", ups, 0);
    chk("mid_no_stale_atten", n, 0);
    for (int i = 0; i < 3000; i++) begin
      Rest = $urandom_range(0, 399) == 0;
      if ($urandom_range(0, 149) == 0) AttenEnable = !AttenEnable;
      set_in($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
